// File: rtl/chunked_add.sv
// Multi-cycle adder/subtractor: computes A+B+Cin or A-B one CHUNK-bit slice per clock,
// producing registered Sum, carry-out and signed overflow behind a start/busy/done handshake.
module chunked_add #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_add: WIDTH must be >= 2 and an exact multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] part;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic [WIDTH-1:0] full_sum;

    // Overflow compares against the operand actually added, i.e. the inverted B when subtracting.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    always_comb begin
        a_ch     = op_a[k*CHUNK +: CHUNK];
        b_ch     = op_b[k*CHUNK +: CHUNK];
        ch_sum   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        full_sum = part;
        full_sum[k*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            k     <= '0;
            carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry <= sub | cin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= ch_sum[CHUNK];
                    if (k == K_LAST) begin
                        k     <= '0;
                        sum   <= full_sum;
                        cout  <= ch_sum[CHUNK];
                        ovf   <= signed_ovf(op_a[WIDTH-1], op_b[WIDTH-1], full_sum[WIDTH-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand and partial-sum storage is pure datapath and needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
        end else if (state == RUN) begin
            part[k*CHUNK +: CHUNK] <= ch_sum[CHUNK-1:0];
        end
    end

endmodule
